line_dir_arbiter: RTL
=====================

Name: line_dir_arbiter

Overview:
- Clocked direction controller for a shared half-duplex bidirectional line, e.g. the two ends of a delayed wire model.
- Grants line ownership to side A or side B and drives the per-side output enables.
- Inserts a mandatory turnaround gap with both drivers off, so the line floats and the wire delay drains before the other side drives.
- Fairness: round-robin on simultaneous requests, plus preemption after a maximum hold time.

Parameters:
- TURN_CYC, 2, idle cycles with both enables low between any release and the next grant; legal range ≥1.
- MAX_HOLD, 16, max consecutive owner cycles while the other side is requesting; 0 disables preemption.
- CNT_W, 8, width of the internal hold and turn counters; must hold max(TURN_CYC, MAX_HOLD).

Ports:
- clk, input, 1, single clock for all logic.
- rst, input, 1, synchronous active-high reset.
- req_a, input, 1, side A requests line ownership; level, held while it wants the line.
- req_b, input, 1, side B requests line ownership.
- gnt_a, output, 1, side A owns the line.
- gnt_b, output, 1, side B owns the line.
- oe_a, output, 1, side A driver enable; equals gnt_a.
- oe_b, output, 1, side B driver enable; equals gnt_b.
- turn, output, 1, high during the turnaround gap.
- busy, output, 1, high in any state other than IDLE.
- preempt, output, 1, one-cycle pulse when a grant is revoked by the MAX_HOLD limit.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high.
- All outputs are registered. On reset all outputs are 0, state is IDLE, counters are 0, and last_owner is B, so A wins the first tie.
- FSM states: IDLE, OWN_A, OWN_B, TURN.
- IDLE:
  - Samples requests each edge.
  - One request pending → the matching OWN state; gnt/oe high in the cycle after req is first seen (latency 1).
  - Both pending → grant the side that is not last_owner.
- OWN_x:
  - Set last_owner = x on entry; hold_cnt clears on entry and increments each cycle.
  - Exit to TURN when req_x is low at an edge; gnt_x/oe_x fall the following cycle.
  - Exit to TURN when MAX_HOLD≠0, the other side is requesting, and hold_cnt == MAX_HOLD-1; preempt pulses for one cycle together with the gnt fall.
  - When the other side is not requesting, hold is unlimited.
- TURN:
  - turn=1; gnt_a = gnt_b = 0; lasts exactly TURN_CYC cycles.
  - On the final cycle, arbitrate the pending requests: prefer the side that is not last_owner; otherwise grant the only requester, including the same side again.
  - No request pending → IDLE.
- Every release passes through TURN, including a release with no competing request.
- Invariants:
  - gnt_a and gnt_b are never both high.
  - oe_x is never high in TURN or IDLE.
  - turn, gnt_a and gnt_b are mutually exclusive.
- Requests may drop while waiting; a request dropped before the arbitration edge is not granted.
- A request asserted during TURN is honoured at the end of TURN; the turnaround is not shortened.
- Reset asserted mid-grant or mid-TURN forces IDLE and all outputs 0 on the next edge. There is no turnaround after reset; the external side is responsible for the line state.
- Counters never wrap: hold_cnt saturates at its max when preemption is disabled.

Test Plan:
- Reset then req_a=1 at cycle 0 → gnt_a=oe_a=1 from cycle 1; busy=1; gnt_b=0 throughout.
- req_a and req_b both rise at cycle 0 after reset → gnt_a at cycle 1. Drop req_a at cycle 5 → turn=1 for cycles 6-7 (TURN_CYC=2), gnt_b=1 at cycle 8.
- A owns the line and req_b is held high with MAX_HOLD=16 → gnt_a high exactly 16 cycles, then preempt pulses with the gnt_a fall. After 2 turn cycles gnt_b=1; req_a still high → A regains the line after B releases.
- A holds the line for 100 cycles with req_b=0 → no preemption; release → 2 turn cycles → IDLE, busy=0.
- rst asserted during OWN_B and during TURN → next cycle gnt/oe/turn/busy all 0. Requests held → grant 1 cycle after rst deasserts, A wins the tie.
- Random req_a/req_b for 10k cycles → assertions hold: never gnt_a&gnt_b; at least TURN_CYC zero-enable cycles between any two grants; every grant is preceded by a request in the previous cycle.

Source files
------------

// File: rtl/line_dir_arbiter_if.sv
// line_dir_arbiter_if: request/grant bundle between the two line endpoints and the direction arbiter.
// Revision: 1.0
`default_nettype none

interface line_dir_arbiter_if;
   logic req_a;
   logic req_b;
   logic gnt_a;
   logic gnt_b;
   logic oe_a;
   logic oe_b;
   logic turn;
   logic busy;
   logic preempt;

   modport master (
      output req_a, req_b,
      input  gnt_a, gnt_b, oe_a, oe_b, turn, busy, preempt
   );

   modport slave (
      input  req_a, req_b,
      output gnt_a, gnt_b, oe_a, oe_b, turn, busy, preempt
   );
endinterface

`default_nettype wire

// File: rtl/line_dir_arbiter.sv
// line_dir_arbiter: half-duplex line direction controller with turnaround gap,
// round-robin tie break and max-hold preemption. Revision: 1.0
`default_nettype none

module line_dir_arbiter #(
   parameter int TURN_CYC = 2,
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 8
) (
   input wire logic          clk,
   input wire logic          rst,
   line_dir_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_OWN_A = 2'd1,
      S_OWN_B = 2'd2,
      S_TURN  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] c_TURN_LAST  = CNT_W'(TURN_CYC - 1);
   localparam logic [CNT_W-1:0] c_HOLD_LAST  = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
   localparam logic             c_PREEMPT_EN = (MAX_HOLD != 0);
   localparam logic [CNT_W-1:0] c_CNT_MAX    = '1;

   state_t           r_state;
   state_t           w_next;
   logic             r_last_b;
   logic [CNT_W-1:0] r_hold_cnt;
   logic [CNT_W-1:0] r_turn_cnt;
   logic             r_gnt_a;
   logic             r_gnt_b;
   logic             r_turn;
   logic             r_busy;
   logic             r_preempt;
   logic             w_preempt;
   logic             w_arb_a;
   logic             w_arb_b;
   logic             w_hold_hit;
   logic             w_own;

   // On a tie the side that did not own the line last wins.
   assign w_arb_a    = bus.req_a & (~bus.req_b | r_last_b);
   assign w_arb_b    = bus.req_b & (~bus.req_a | ~r_last_b);
   assign w_hold_hit = c_PREEMPT_EN && (r_hold_cnt >= c_HOLD_LAST);
   assign w_own      = (r_state == S_OWN_A) || (r_state == S_OWN_B);

   always_comb begin
      w_next    = r_state;
      w_preempt = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_arb_a) begin
               w_next = S_OWN_A;
            end else if (w_arb_b) begin
               w_next = S_OWN_B;
            end
         end
         S_OWN_A: begin
            if (!bus.req_a) begin
               w_next = S_TURN;
            end else if (bus.req_b && w_hold_hit) begin
               w_next    = S_TURN;
               w_preempt = 1'b1;
            end
         end
         S_OWN_B: begin
            if (!bus.req_b) begin
               w_next = S_TURN;
            end else if (bus.req_a && w_hold_hit) begin
               w_next    = S_TURN;
               w_preempt = 1'b1;
            end
         end
         S_TURN: begin
            if (r_turn_cnt == c_TURN_LAST) begin
               if (w_arb_a) begin
                  w_next = S_OWN_A;
               end else if (w_arb_b) begin
                  w_next = S_OWN_B;
               end else begin
                  w_next = S_IDLE;
               end
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_last_b   <= 1'b1;
         r_hold_cnt <= '0;
         r_turn_cnt <= '0;
         r_gnt_a    <= 1'b0;
         r_gnt_b    <= 1'b0;
         r_turn     <= 1'b0;
         r_busy     <= 1'b0;
         r_preempt  <= 1'b0;
      end else begin
         r_state <= w_next;

         if (w_next == S_OWN_A) begin
            r_last_b <= 1'b0;
         end else if (w_next == S_OWN_B) begin
            r_last_b <= 1'b1;
         end

         // Saturating so an unlimited hold never wraps back into the preempt window.
         if (w_next != r_state || !w_own) begin
            r_hold_cnt <= '0;
         end else if (r_hold_cnt != c_CNT_MAX) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
         end

         if (w_next == S_TURN && r_state == S_TURN) begin
            r_turn_cnt <= r_turn_cnt + 1'b1;
         end else begin
            r_turn_cnt <= '0;
         end

         r_gnt_a   <= (w_next == S_OWN_A);
         r_gnt_b   <= (w_next == S_OWN_B);
         r_turn    <= (w_next == S_TURN);
         r_busy    <= (w_next != S_IDLE);
         r_preempt <= w_preempt;
      end
   end

   assign bus.gnt_a   = r_gnt_a;
   assign bus.gnt_b   = r_gnt_b;
   assign bus.oe_a    = r_gnt_a;
   assign bus.oe_b    = r_gnt_b;
   assign bus.turn    = r_turn;
   assign bus.busy    = r_busy;
   assign bus.preempt = r_preempt;

endmodule

`default_nettype wire
